// File: rtl/in_service_rotating.sv
// In-service register with rotating priority: ack/EOI/rotate/set-priority handling for NUM_IRQ channels.
// Optional build macro IN_SERVICE_AUTO_EOI_EN enables auto-EOI acknowledge handling.
module in_service_rotating #(
    parameter  int NUM_IRQ = 8,
    localparam int LEVEL_W = $clog2(NUM_IRQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] pending_request,
    input  logic               ack,
    input  logic               eoi,
    input  logic               specific_eoi,
    input  logic               rotate,
    input  logic               set_priority,
    input  logic [LEVEL_W-1:0] cmd_level,
    input  logic               auto_eoi,
    output logic [NUM_IRQ-1:0] in_service,
    output logic [LEVEL_W-1:0] lowest_priority,
    output logic               int_request,
    output logic [LEVEL_W-1:0] ack_level,
    output logic               spurious
);

    // Returns {hit, rank}; rank 0 is the level just above lp in the rotated order.
    function automatic logic [LEVEL_W:0] hp_search(input logic [NUM_IRQ-1:0] vec,
                                                   input logic [LEVEL_W-1:0] lp);
        logic [LEVEL_W:0]   r;
        logic [LEVEL_W-1:0] idx;
        r = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            idx = lp + LEVEL_W'(k + 1);
            if (vec[idx]) r = {1'b1, LEVEL_W'(k)};
        end
        return r;
    endfunction

    logic               auto_mode;
`ifdef IN_SERVICE_AUTO_EOI_EN
    assign auto_mode = auto_eoi;
`else
    logic unused_auto_eoi;
    assign unused_auto_eoi = auto_eoi;
    assign auto_mode       = 1'b0;
`endif

    logic [LEVEL_W:0]   pend_s, isr_s;
    logic               pend_hit, isr_hit;
    logic [LEVEL_W-1:0] pend_rank, isr_rank, hp_pend, hp_isr;

    assign pend_s    = hp_search(pending_request, lowest_priority);
    assign isr_s     = hp_search(in_service, lowest_priority);
    assign pend_hit  = pend_s[LEVEL_W];
    assign isr_hit   = isr_s[LEVEL_W];
    assign pend_rank = pend_s[LEVEL_W-1:0];
    assign isr_rank  = isr_s[LEVEL_W-1:0];
    assign hp_pend   = lowest_priority + pend_rank + LEVEL_W'(1);
    assign hp_isr    = lowest_priority + isr_rank + LEVEL_W'(1);

    // Smaller rank means higher priority, so a strict compare gives "outranks".
    assign int_request = pend_hit && (!isr_hit || (pend_rank < isr_rank));

    logic [NUM_IRQ-1:0] isr_nxt;
    logic [LEVEL_W-1:0] lp_nxt, al_nxt;
    logic               spur_nxt;

    always_comb begin
        isr_nxt  = in_service;
        lp_nxt   = lowest_priority;
        al_nxt   = ack_level;
        spur_nxt = 1'b0;

        // EOI clear lands before the ack set, so a same-bit collision leaves the bit set.
        if (specific_eoi) begin
            isr_nxt[cmd_level] = 1'b0;
            if (rotate) lp_nxt = cmd_level;
        end else if (eoi && isr_hit) begin
            isr_nxt[hp_isr] = 1'b0;
            if (rotate) lp_nxt = hp_isr;
        end

        if (ack) begin
            if (pend_hit) begin
                al_nxt = hp_pend;
                if (!auto_mode)  isr_nxt[hp_pend] = 1'b1;
                else if (rotate) lp_nxt = hp_pend;
            end else begin
                spur_nxt = 1'b1;
            end
        end

        if (set_priority) lp_nxt = cmd_level;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            in_service      <= '0;
            lowest_priority <= LEVEL_W'(NUM_IRQ - 1);
            ack_level       <= '0;
            spurious        <= 1'b0;
        end else begin
            in_service      <= isr_nxt;
            lowest_priority <= lp_nxt;
            ack_level       <= al_nxt;
            spurious        <= spur_nxt;
        end
    end

endmodule
